// File: rtl/axis_rr_merge.sv
// Round-robin 3:1 AXI-Stream merge with packet lock; optional m_axis_tid via AXIS_MERGE_TID_EN.
// One registered output stage, 1 beat/clk; a stalled output register blocks every input (tready=0).
module axis_rr_merge #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4,
    parameter int PKT_LOCK   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
    input  logic                  s_axis_tvalid_0,
    output logic                  s_axis_tready_0,
    input  logic                  s_axis_tlast_0,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
    input  logic                  s_axis_tvalid_1,
    output logic                  s_axis_tready_1,
    input  logic                  s_axis_tlast_1,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
    input  logic                  s_axis_tvalid_2,
    output logic                  s_axis_tready_2,
    input  logic                  s_axis_tlast_2,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
`ifdef AXIS_MERGE_TID_EN
    ,
    output logic [1:0]            m_axis_tid
`endif
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            last_grant_q, last_grant_d;
    logic [1:0]            lock_src_q, lock_src_d;

    logic [1:0]            grant;
    logic                  grant_valid;
    logic                  load_ok;
    logic                  acc;
    logic                  sel_last;
    logic [2:0]            in_vld;
    logic [2:0]            in_last;
    logic [2:0]            in_rdy;
    logic [DATA_WIDTH-1:0] in_data [3];
    logic [KEEP_WIDTH-1:0] in_keep [3];

    logic                  m_tvalid_q;
    logic [DATA_WIDTH-1:0] m_tdata_q;
    logic [KEEP_WIDTH-1:0] m_tkeep_q;
    logic                  m_tlast_q;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    assign in_vld     = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
    assign in_last    = {s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};
    assign in_data[0] = s_axis_tdata_0;
    assign in_data[1] = s_axis_tdata_1;
    assign in_data[2] = s_axis_tdata_2;
    assign in_keep[0] = s_axis_tkeep_0;
    assign in_keep[1] = s_axis_tkeep_1;
    assign in_keep[2] = s_axis_tkeep_2;

    assign load_ok  = ~m_tvalid_q | m_axis_tready;
    assign acc      = |(in_vld & in_rdy);
    assign sel_last = in_last[grant];

    assign s_axis_tready_0 = in_rdy[0];
    assign s_axis_tready_1 = in_rdy[1];
    assign s_axis_tready_2 = in_rdy[2];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 2'd2;
            lock_src_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_src_q   <= lock_src_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_src_d   = lock_src_q;
        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    last_grant_d = grant;
                    if ((PKT_LOCK != 0) && !sel_last) begin
                        state_d    = ST_LOCKED;
                        lock_src_d = grant;
                    end
                end
            end
            ST_LOCKED: begin
                if (acc && sel_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: grant selection and per-input ready
    always_comb begin
        logic [1:0] c1, c2, c3;
        c1          = next_idx(last_grant_q);
        c2          = next_idx(c1);
        c3          = next_idx(c2);
        grant       = c1;
        grant_valid = 1'b0;
        if (state_q == ST_LOCKED) begin
            // locked source keeps ready even through a tvalid gap
            grant       = lock_src_q;
            grant_valid = 1'b1;
        end else if (in_vld[c1]) begin
            grant       = c1;
            grant_valid = 1'b1;
        end else if (in_vld[c2]) begin
            grant       = c2;
            grant_valid = 1'b1;
        end else if (in_vld[c3]) begin
            grant       = c3;
            grant_valid = 1'b1;
        end
        for (int n = 0; n < 3; n++) begin
            in_rdy[n] = ~rst & load_ok & grant_valid & (grant == 2'(n));
        end
    end

    // Output register: loads the accepted beat, empties when drained with nothing new
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
        end else if (load_ok) begin
            m_tvalid_q <= acc;
            if (acc) begin
                m_tdata_q <= in_data[grant];
                m_tkeep_q <= in_keep[grant];
                m_tlast_q <= sel_last;
            end
        end
    end

    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tlast  = m_tlast_q;

`ifdef AXIS_MERGE_TID_EN
    logic [1:0] m_tid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tid_q <= 2'd0;
        end else if (load_ok && acc) begin
            m_tid_q <= grant;
        end
    end

    assign m_axis_tid = m_tid_q;
`endif

endmodule

// File: tb/tb_axis_rr_merge.sv
// Self-checking bench for axis_rr_merge: packet-locked instance plus a per-beat (PKT_LOCK=0) instance.
module tb_axis_rr_merge;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic [1:0]  src;
    } beat_t;

    logic        clk;
    logic        rst;

    logic [31:0] s_tdata [3];
    logic [3:0]  s_tkeep [3];
    logic [2:0]  s_tvalid;
    logic [2:0]  s_tready;
    logic [2:0]  s_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;

    logic [31:0] nl_tdata [3];
    logic [3:0]  nl_tkeep [3];
    logic [2:0]  nl_tvalid;
    logic [2:0]  nl_tready;
    logic [2:0]  nl_tlast;
    logic [31:0] nl_m_tdata;
    logic [3:0]  nl_m_tkeep;
    logic        nl_m_tvalid;
    logic        nl_m_tready;
    logic        nl_m_tlast;

`ifdef AXIS_MERGE_TID_EN
    logic [1:0]  m_tid;
    logic [1:0]  nl_m_tid;
`endif

    int    checks;
    int    errors;
    beat_t exp_q[$];
    int    nl_exp_q[$];
    beat_t mon_e;

    axis_rr_merge #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .PKT_LOCK(1)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata_0(s_tdata[0]), .s_axis_tkeep_0(s_tkeep[0]), .s_axis_tvalid_0(s_tvalid[0]),
        .s_axis_tready_0(s_tready[0]), .s_axis_tlast_0(s_tlast[0]),
        .s_axis_tdata_1(s_tdata[1]), .s_axis_tkeep_1(s_tkeep[1]), .s_axis_tvalid_1(s_tvalid[1]),
        .s_axis_tready_1(s_tready[1]), .s_axis_tlast_1(s_tlast[1]),
        .s_axis_tdata_2(s_tdata[2]), .s_axis_tkeep_2(s_tkeep[2]), .s_axis_tvalid_2(s_tvalid[2]),
        .s_axis_tready_2(s_tready[2]), .s_axis_tlast_2(s_tlast[2]),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast)
`ifdef AXIS_MERGE_TID_EN
        , .m_axis_tid(m_tid)
`endif
    );

    axis_rr_merge #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .PKT_LOCK(0)) dut_nl (
        .clk(clk), .rst(rst),
        .s_axis_tdata_0(nl_tdata[0]), .s_axis_tkeep_0(nl_tkeep[0]), .s_axis_tvalid_0(nl_tvalid[0]),
        .s_axis_tready_0(nl_tready[0]), .s_axis_tlast_0(nl_tlast[0]),
        .s_axis_tdata_1(nl_tdata[1]), .s_axis_tkeep_1(nl_tkeep[1]), .s_axis_tvalid_1(nl_tvalid[1]),
        .s_axis_tready_1(nl_tready[1]), .s_axis_tlast_1(nl_tlast[1]),
        .s_axis_tdata_2(nl_tdata[2]), .s_axis_tkeep_2(nl_tkeep[2]), .s_axis_tvalid_2(nl_tvalid[2]),
        .s_axis_tready_2(nl_tready[2]), .s_axis_tlast_2(nl_tlast[2]),
        .m_axis_tdata(nl_m_tdata), .m_axis_tkeep(nl_m_tkeep), .m_axis_tvalid(nl_m_tvalid),
        .m_axis_tready(nl_m_tready), .m_axis_tlast(nl_m_tlast)
`ifdef AXIS_MERGE_TID_EN
        , .m_axis_tid(nl_m_tid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every beat leaving the locked instance must match the head of exp_q
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got data=%h last=%b, expected no beat", m_tdata, m_tlast);
            end else begin
                mon_e = exp_q.pop_front();
                if ({m_tdata, m_tkeep, m_tlast} !== {mon_e.d, mon_e.k, mon_e.l}) begin
                    errors++;
                    $display("FAIL sb_beat got d=%h k=%h l=%b expected d=%h k=%h l=%b",
                             m_tdata, m_tkeep, m_tlast, mon_e.d, mon_e.k, mon_e.l);
                end
`ifdef AXIS_MERGE_TID_EN
                checks++;
                if (m_tid !== mon_e.src) begin
                    errors++;
                    $display("FAIL sb_tid got %0d expected %0d", m_tid, mon_e.src);
                end
`endif
            end
        end
    end

    task automatic push_exp(input int p, input int n, input logic [31:0] base);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d   = base + 32'(i);
            b.k   = (i == n - 1) ? 4'h7 : 4'hF;
            b.l   = (i == n - 1);
            b.src = 2'(p);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_pkt(input int p, input int n, input logic [31:0] base,
                            input int gap_at, input int gap_len);
        logic hs;
        int   t;
        for (int i = 0; i < n; i++) begin
            s_tdata[p]  = base + 32'(i);
            s_tkeep[p]  = (i == n - 1) ? 4'h7 : 4'hF;
            s_tlast[p]  = (i == n - 1);
            s_tvalid[p] = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                hs = s_tvalid[p] && s_tready[p];
                t++;
            end while (!hs && t < 200);
            if (!hs) begin
                checks++;
                errors++;
                $display("FAIL send_timeout port=%0d beat=%0d got no handshake, expected one", p, i);
            end
            @(posedge clk);
            #1;
            s_tvalid[p] = 1'b0;
            if (i == gap_at) begin
                repeat (gap_len) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        m_tready = 1'b1;
        nl_m_tready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            s_tdata[p]  = 32'hD0 + 32'(p);
            s_tkeep[p]  = 4'hF;
            nl_tdata[p] = 32'hD0 + 32'(p);
            nl_tkeep[p] = 4'hF;
        end
        s_tlast   = 3'b111;
        s_tvalid  = 3'b111;
        nl_tlast  = 3'b000;
        nl_tvalid = 3'b111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_tready !== 3'b000) begin
            errors++;
            $display("FAIL reset_tready got %b expected 000", s_tready);
        end
        checks++;
        if (nl_tready !== 3'b000) begin
            errors++;
            $display("FAIL reset_nl_tready got %b expected 000", nl_tready);
        end
        checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got v=%b l=%b expected 0 0", m_tvalid, m_tlast);
        end
        checks++;
        if (m_tdata !== 32'h0 || m_tkeep !== 4'h0) begin
            errors++;
            $display("FAIL reset_payload got d=%h k=%h expected 0 0", m_tdata, m_tkeep);
        end
`ifdef AXIS_MERGE_TID_EN
        checks++;
        if (m_tid !== 2'd0) begin
            errors++;
            $display("FAIL reset_tid got %0d expected 0", m_tid);
        end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_tready !== 3'b001) begin
            errors++;
            $display("FAIL first_grant got tready=%b expected 001", s_tready);
        end
        s_tvalid  = 3'b000;
        nl_tvalid = 3'b000;
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got m_tvalid=%b expected 0", m_tvalid);
        end
    endtask

    task automatic test_round_robin();
        push_exp(0, 2, 32'hA0);
        push_exp(1, 2, 32'hB0);
        push_exp(2, 2, 32'hC0);
        @(posedge clk);
        #1;
        fork
            send_pkt(0, 2, 32'hA0, -1, 0);
            send_pkt(1, 2, 32'hB0, -1, 0);
            send_pkt(2, 2, 32'hC0, -1, 0);
        join
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_drain got %0d beats pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_single_packet();
        push_exp(1, 4, 32'h11);
        @(posedge clk);
        #1;
        fork
            send_pkt(1, 4, 32'h11, -1, 0);
            begin
                int t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!(s_tvalid[1] && s_tready[1]) && t < 200);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    checks++;
                    if (m_tvalid !== 1'b1 || m_tdata !== 32'h11 + 32'(i) || m_tlast !== (i == 3)) begin
                        errors++;
                        $display("FAIL single_beat%0d got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                                 i, m_tvalid, m_tdata, m_tlast, 32'h11 + 32'(i), (i == 3));
                    end
                end
            end
        join
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_drain got %0d beats pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        push_exp(0, 3, 32'h40);
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        fork
            send_pkt(0, 3, 32'h40, -1, 0);
            begin
                int t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!m_tvalid && t < 200);
                @(posedge clk);
                #1;
                m_tready = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    @(negedge clk);
                    checks++;
                    if (m_tvalid !== 1'b1 || m_tdata !== 32'h41) begin
                        errors++;
                        $display("FAIL stall_hold%0d got v=%b d=%h expected v=1 d=00000041",
                                 i, m_tvalid, m_tdata);
                    end
                    checks++;
                    if (s_tready[0] !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_tready%0d got %b expected 0", i, s_tready[0]);
                    end
                    if (i == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain got %0d beats pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_lock_hold();
        push_exp(2, 3, 32'h50);
        push_exp(0, 2, 32'h60);
        @(posedge clk);
        #1;
        fork
            send_pkt(2, 3, 32'h50, 0, 3);
            begin
                @(posedge clk);
                #1;
                send_pkt(0, 2, 32'h60, -1, 0);
            end
            begin
                @(posedge clk);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    checks++;
                    if (s_tready[0] !== 1'b0 || s_tvalid[0] !== 1'b1) begin
                        errors++;
                        $display("FAIL lock_block%0d got v0=%b rdy0=%b expected v0=1 rdy0=0",
                                 i, s_tvalid[0], s_tready[0]);
                    end
                end
            end
        join
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL lock_drain got %0d beats pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_no_lock();
        int t = 0;
        int src;
        nl_exp_q = '{0, 1, 2, 0};
        @(posedge clk);
        #1;
        for (int p = 0; p < 3; p++) begin
            nl_tdata[p] = 32'h100 + 32'(p);
            nl_tkeep[p] = 4'hF;
        end
        nl_tlast    = 3'b000;
        nl_tvalid   = 3'b111;
        nl_m_tready = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!nl_m_tvalid && t < 200);
        while (nl_exp_q.size() != 0) begin
            src = nl_exp_q.pop_front();
            checks++;
            if (nl_m_tvalid !== 1'b1 || nl_m_tdata !== 32'h100 + 32'(src)) begin
                errors++;
                $display("FAIL nolock_rot got v=%b d=%h expected v=1 d=%h",
                         nl_m_tvalid, nl_m_tdata, 32'h100 + 32'(src));
            end
`ifdef AXIS_MERGE_TID_EN
            checks++;
            if (nl_m_tid !== 2'(src)) begin
                errors++;
                $display("FAIL nolock_tid got %0d expected %0d", nl_m_tid, src);
            end
`endif
            @(negedge clk);
        end
        nl_tvalid = 3'b000;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        s_tvalid = 3'b000;
        s_tlast  = 3'b000;
        nl_tvalid = 3'b000;
        nl_tlast  = 3'b000;
        m_tready = 1'b1;
        nl_m_tready = 1'b1;
        test_reset();
        test_round_robin();
        test_single_packet();
        test_stall();
        test_lock_hold();
        test_no_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
